instmem_arbiter: RTL and testbench
==================================

// Module: instmem_arbiter
// PURPOSE
//  Sequences and shares the single instmem port between two requesters.
//  Requester R is the instcache refill (block read); requester W is the loader (block write).
//  Grants one access at a time with round-robin priority and holds instmem controls for a fixed latency.
//  Returns each requester a one-cycle done pulse; read data is captured from instmem out1.
//  Sits between instcache/loader and instmem inside CPU.
// PARAMETERS
//  ADDR_W   `WORD_SIZE   width of block address presented to instmem 'in'
//  BLOCK_W  `BLOCK_SIZE  width of one memory block (read data / write data)
//  MEM_LAT  2            cycles instmem controls are held before out1 is valid / write committed (>=1)
// PORTS
//  clk          in   1        system clock, all state on rising edge
//  rst          in   1        synchronous reset, active-high
//  rd_req       in   1        refill request; held high until rd_done
//  rd_addr      in   ADDR_W   refill block address; stable while rd_req high
//  rd_done      out  1        one-cycle pulse: rd_data valid this cycle
//  rd_data      out  BLOCK_W  captured read block; holds until next read completes
//  wr_req       in   1        write request; held high until wr_done
//  wr_addr      in   ADDR_W   write block address; stable while wr_req high
//  wr_data      in   BLOCK_W  block to write; stable while wr_req high
//  wr_done      out  1        one-cycle pulse: write committed
//  busy         out  1        high in any state other than IDLE
//  mem_in       out  ADDR_W   to instmem 'in'
//  mem_readable out  1        to instmem 'readable'
//  mem_writable out  1        to instmem 'writable'
//  mem_write    out  BLOCK_W  to instmem 'write'
//  mem_out1     in   BLOCK_W  from instmem 'out1'
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, last=W (so R wins first tie); all outputs 0 incl. rd_data.
//  FSM states: IDLE, READ, WRITE, DONE.
//  IDLE: rd_req only -> READ; wr_req only -> WRITE; both -> side not equal to 'last'; none -> IDLE.
//   On grant: latch address (and wr_data) into registers, cnt<=0, last<=granted side.
//  READ: mem_in=addr reg, mem_readable=1, mem_writable=0; cnt increments each cycle;
//   at cnt==MEM_LAT-1 capture mem_out1 into rd_data, go DONE.
//  WRITE: mem_in=addr reg, mem_write=data reg, mem_writable=1, mem_readable=0;
//   at cnt==MEM_LAT-1 go DONE.
//  DONE: exactly one cycle; pulse rd_done or wr_done for the granted side; mem_* all 0; -> IDLE.
//  mem_readable and mem_writable never both 1; mem_* are 0 in IDLE and DONE.
//  Latency, uncontended: req seen in IDLE at cycle 0 -> done pulse at cycle MEM_LAT+1.
//  Back-to-back: requester keeps req high after done -> treated as new request in next IDLE cycle.
//  Requester must drop req the cycle after its done; req deasserted mid-access is ignored (access completes, done still pulses).
//  Contention: with both held continuously, grants alternate R,W,R,W; no starvation.
//  cnt width = clog2(MEM_LAT)+1; no wrap inside an access.
//  rst mid-access: aborts immediately, no done pulse, memory controls drop next edge, rd_data cleared.
// TESTING
//  1 Reset: rst=1 2 cycles with reqs high -> all outputs 0, busy=0; release -> R granted first.
//  2 Read: rd_req=1, rd_addr=5, mem_out1=block B -> mem_readable=1 with mem_in=5 for 2 cycles, rd_done pulse at cycle 3, rd_data=B.
//  3 Write: wr_req=1, wr_addr=9, wr_data=1024'b11110 -> mem_writable=1 and mem_write=11110 for 2 cycles, wr_done at cycle 3, mem_readable=0 throughout.
//  4 Contention: rd_req and wr_req held high 4 transactions -> order R,W,R,W; one done pulse each; never both mem enables.
//  5 Reset mid-read: rst asserted at cnt=1 -> no rd_done, next cycle mem_readable=0, state IDLE.
//  6 MEM_LAT=1 build: read request -> rd_done at cycle 2, data equals mem_out1 at cycle 1.

Source files
------------

// File: rtl/instmem_arbiter.sv
// rtl/instmem_arbiter.sv - round-robin sharing of the instmem port between cache refill and loader
//
// Purpose: grants one instmem access at a time to either the instcache refill (R, block read)
// or the loader (W, block write). Instmem controls are held for MEM_LAT cycles, then a one-cycle
// DONE state pulses the granted side's done output. Ties go to the side not granted last.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   rd_req/rd_addr            refill request and block address (held until rd_done)
//   rd_done/rd_data           one-cycle completion pulse; captured read block (held)
//   wr_req/wr_addr/wr_data    write request, block address and block (held until wr_done)
//   wr_done                   one-cycle completion pulse for a committed write
//   busy                      high whenever the FSM is not IDLE
//   mem_in/mem_readable/mem_writable/mem_write/mem_out1   instmem port
module instmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 1024,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_done,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic               wr_req,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [BLOCK_W-1:0] wr_data,
  output logic               wr_done,
  output logic               busy,
  output logic [ADDR_W-1:0]  mem_in,
  output logic               mem_readable,
  output logic               mem_writable,
  output logic [BLOCK_W-1:0] mem_write,
  input  logic [BLOCK_W-1:0] mem_out1
);

  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               last_w;     // 1: most recent grant went to W (so R wins the next tie)
  logic [ADDR_W-1:0]  addr_q;
  logic [BLOCK_W-1:0] data_q;
  logic               grant_rd, grant_wr, acc_end;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    grant_rd     = 1'b0;
    grant_wr     = 1'b0;
    acc_end      = (cnt == CNT_LAST);
    busy         = 1'b1;
    mem_in       = '0;
    mem_readable = 1'b0;
    mem_writable = 1'b0;
    mem_write    = '0;
    rd_done      = 1'b0;
    wr_done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (rd_req && (!wr_req || last_w)) begin
          grant_rd  = 1'b1;
          state_nxt = READ;
        end else if (wr_req) begin
          grant_wr  = 1'b1;
          state_nxt = WRITE;
        end
      end
      READ: begin
        mem_in       = addr_q;
        mem_readable = 1'b1;
        if (acc_end) state_nxt = DONE;
      end
      WRITE: begin
        mem_in       = addr_q;
        mem_write    = data_q;
        mem_writable = 1'b1;
        if (acc_end) state_nxt = DONE;
      end
      DONE: begin
        // last_w still names the side granted for the access just finished
        rd_done   = !last_w;
        wr_done   = last_w;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      last_w  <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      rd_data <= '0;
    end else begin
      if (grant_rd || grant_wr) begin
        cnt    <= '0;
        last_w <= grant_wr;
        addr_q <= grant_rd ? rd_addr : wr_addr;
        if (grant_wr) data_q <= wr_data;
      end else if ((state == READ || state == WRITE) && !acc_end) begin
        cnt <= cnt + CW'(1);
      end
      if (state == READ && acc_end) rd_data <= mem_out1;
    end
  end

endmodule

// File: tb/tb_instmem_arbiter.sv
// tb/tb_instmem_arbiter.sv - directed scoreboard bench for instmem_arbiter
module tb_instmem_arbiter;
  localparam int AW = 32;
  localparam int BW = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // MEM_LAT=2 instance
  logic          rd_req, wr_req, rd_done, wr_done, busy, mem_readable, mem_writable;
  logic [AW-1:0] rd_addr, wr_addr, mem_in;
  logic [BW-1:0] rd_data, wr_data, mem_write, mem_out1;

  // MEM_LAT=1 instance
  logic          q_rd_req, q_wr_req, q_rd_done, q_wr_done, q_busy, q_mem_readable, q_mem_writable;
  logic [AW-1:0] q_rd_addr, q_wr_addr, q_mem_in;
  logic [BW-1:0] q_rd_data, q_wr_data, q_mem_write, q_mem_out1;

  instmem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
    .busy(busy), .mem_in(mem_in), .mem_readable(mem_readable), .mem_writable(mem_writable),
    .mem_write(mem_write), .mem_out1(mem_out1)
  );

  instmem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .rd_req(q_rd_req), .rd_addr(q_rd_addr), .rd_done(q_rd_done), .rd_data(q_rd_data),
    .wr_req(q_wr_req), .wr_addr(q_wr_addr), .wr_data(q_wr_data), .wr_done(q_wr_done),
    .busy(q_busy), .mem_in(q_mem_in), .mem_readable(q_mem_readable), .mem_writable(q_mem_writable),
    .mem_write(q_mem_write), .mem_out1(q_mem_out1)
  );

  typedef struct {
    bit            is_wr;
    logic [BW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input bit is_wr, input logic [BW-1:0] data);
    exp_t e;
    e.is_wr = is_wr;
    e.data  = data;
    sb.push_back(e);
  endtask

  // Called in a cycle where a done pulse is expected: pops the oldest expectation.
  task automatic check_done(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=done expected=no_pending", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_kind"}, BW'({rd_done, wr_done}), BW'(e.is_wr ? 2'b01 : 2'b10));
      if (!e.is_wr) chk({tag, "_rdata"}, rd_data, e.data);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      chk({tag, "_excl"}, BW'(mem_readable & mem_writable), '0);
      if (rd_done || wr_done) begin
        seen = 1'b1;
        check_done(tag);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no_done expected=done", tag);
    end
  endtask

  logic [BW-1:0] blk_a, blk_b, blk_c, blk_d, junk;

  initial begin
    blk_a = {32{32'hA0A0_0001}};
    blk_b = {32{32'hB1B2_B3B4}};
    blk_c = {32{32'h0C0C_C0C0}};
    blk_d = {32{32'hDEAD_0042}};
    junk  = {32{32'h5555_AAAA}};
    rst = 1'b1;
    rd_req = 1'b1; wr_req = 1'b1; rd_addr = 32'd7; wr_addr = 32'd3;
    wr_data = blk_c; mem_out1 = blk_a;
    q_rd_req = 1'b0; q_wr_req = 1'b0; q_rd_addr = '0; q_wr_addr = '0;
    q_wr_data = '0; q_mem_out1 = '0;

    // 1: reset with both requests high
    tick(); tick();
    chk("rst_busy", BW'(busy), '0);
    chk("rst_mem_rd", BW'(mem_readable), '0);
    chk("rst_mem_wr", BW'(mem_writable), '0);
    chk("rst_done", BW'({rd_done, wr_done}), '0);
    chk("rst_rdata", rd_data, '0);
    chk("rst_mem_in", BW'(mem_in), '0);
    chk("rst_mem_write", mem_write, '0);
    chk("rst_q_busy", BW'(q_busy), '0);
    rst = 1'b0;
    tick();
    chk("first_grant_rd", BW'({mem_readable, mem_writable}), BW'(2'b10));
    chk("first_grant_addr", BW'(mem_in), BW'(32'd7));
    wr_req = 1'b0;
    push_exp(1'b0, blk_a);
    wait_done("first", 8);
    rd_req = 1'b0;
    tick();
    chk("first_idle", BW'(busy), '0);

    // 2: single read, cycle-exact
    rd_req = 1'b1; rd_addr = 32'd5; mem_out1 = blk_b;
    push_exp(1'b0, blk_b);
    tick();
    chk("rd_c1_en", BW'({mem_readable, mem_writable}), BW'(2'b10));
    chk("rd_c1_in", BW'(mem_in), BW'(32'd5));
    chk("rd_c1_done", BW'(rd_done), '0);
    tick();
    chk("rd_c2_en", BW'({mem_readable, mem_writable}), BW'(2'b10));
    chk("rd_c2_in", BW'(mem_in), BW'(32'd5));
    tick();
    chk("rd_c3_pulse", BW'(rd_done), BW'(1'b1));
    chk("rd_c3_mem", BW'({mem_readable, mem_writable}), '0);
    check_done("rd");
    rd_req = 1'b0; mem_out1 = junk;
    tick();
    chk("rd_c4_done", BW'(rd_done), '0);
    chk("rd_c4_busy", BW'(busy), '0);
    chk("rd_c4_hold", rd_data, blk_b);

    // 3: single write, cycle-exact
    wr_req = 1'b1; wr_addr = 32'd9; wr_data = BW'(5'b11110);
    push_exp(1'b1, '0);
    tick();
    chk("wr_c1_en", BW'({mem_readable, mem_writable}), BW'(2'b01));
    chk("wr_c1_in", BW'(mem_in), BW'(32'd9));
    chk("wr_c1_data", mem_write, BW'(5'b11110));
    tick();
    chk("wr_c2_en", BW'({mem_readable, mem_writable}), BW'(2'b01));
    chk("wr_c2_data", mem_write, BW'(5'b11110));
    tick();
    chk("wr_c3_pulse", BW'(wr_done), BW'(1'b1));
    check_done("wr");
    wr_req = 1'b0;
    tick();
    chk("wr_c4_done", BW'(wr_done), '0);
    chk("wr_c4_hold", rd_data, blk_b);

    // 4: contention, both held for four transactions (last grant was W, so R first)
    rd_req = 1'b1; rd_addr = 32'd20; wr_req = 1'b1; wr_addr = 32'd21;
    wr_data = blk_d; mem_out1 = blk_c;
    push_exp(1'b0, blk_c);
    push_exp(1'b1, '0);
    push_exp(1'b0, blk_c);
    push_exp(1'b1, '0);
    for (int t = 0; t < 4; t++) wait_done($sformatf("cont%0d", t), 8);
    rd_req = 1'b0; wr_req = 1'b0;
    tick();
    chk("cont_idle", BW'(busy), '0);
    chk("cont_sb_empty", BW'(sb.size()), '0);

    // 5: reset while a read is at cnt=1
    rd_req = 1'b1; rd_addr = 32'd33; mem_out1 = blk_d;
    tick();
    tick();
    chk("rstmid_reading", BW'(mem_readable), BW'(1'b1));
    rst = 1'b1;
    tick();
    chk("rstmid_mem_rd", BW'(mem_readable), '0);
    chk("rstmid_busy", BW'(busy), '0);
    chk("rstmid_done", BW'(rd_done), '0);
    chk("rstmid_rdata", rd_data, '0);
    rst = 1'b0; rd_req = 1'b0;
    tick();
    chk("rstmid_nodone", BW'({rd_done, wr_done}), '0);

    // 6: MEM_LAT=1 instance
    q_rd_req = 1'b1; q_rd_addr = 32'd11; q_mem_out1 = blk_a;
    tick();
    chk("lat1_c1_en", BW'(q_mem_readable), BW'(1'b1));
    chk("lat1_c1_in", BW'(q_mem_in), BW'(32'd11));
    q_rd_req = 1'b0;
    tick();
    q_mem_out1 = junk;
    chk("lat1_c2_done", BW'(q_rd_done), BW'(1'b1));
    chk("lat1_c2_rdata", q_rd_data, blk_a);
    tick();
    chk("lat1_c3_done", BW'(q_rd_done), '0);
    chk("lat1_c3_hold", q_rd_data, blk_a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
